// File: rtl/grad_buf_pkg.sv
// Shared types and helpers for the gradient accumulation buffer and its
// control stage: flush causes, controller states, index-width derivation,
// and the signed arithmetic used on accumulated values.
package grad_buf_pkg;

  typedef enum logic [1:0] {
    CAUSE_THRESH = 2'd0,
    CAUSE_FORCE  = 2'd1,
    CAUSE_EVICT  = 2'd2,
    CAUSE_DRAIN  = 2'd3
  } flush_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } ctrl_state_e;

  // Set-index width; kept at least 1 so a single-set buffer still has a port.
  function automatic int calc_siw(input int depth, input int ways);
    int sets;
    sets = depth / ways;
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  // Way-index width; kept at least 1 for a direct-mapped buffer.
  function automatic int calc_wiw(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Signed 32-bit add that clamps to 0x7fffffff / 0x80000000 on overflow.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {a[31], a} + {b[31], b};
    if (sum[32] != sum[31]) begin
      return sum[32] ? 32'h8000_0000 : 32'h7fff_ffff;
    end
    return sum[31:0];
  endfunction

  // Unsigned magnitude of a signed 32-bit value; 33 bits so -2^31 is exact.
  function automatic logic [32:0] abs33(input logic [31:0] v);
    return v[31] ? (33'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

endpackage

// File: rtl/grad_way_select.sv
// Combinational way lookup for one set: reports the way whose valid tag
// matches the request address, and the lowest-index invalid way.
module grad_way_select #(
  parameter int NUM_WAYS = 4,
  parameter int WIW      = 2
) (
  input  logic [NUM_WAYS-1:0]       i_valid,
  input  logic [NUM_WAYS-1:0][31:0] i_tag,
  input  logic [31:0]               i_addr,
  output logic                      o_hit,
  output logic [WIW-1:0]            o_hit_way,
  output logic                      o_free,
  output logic [WIW-1:0]            o_free_way
);

  // Scan from the top way down so the lowest-index match is the one kept.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_way  = '0;
    o_free     = 1'b0;
    o_free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (i_valid[w] && (i_tag[w] == i_addr)) begin
        o_hit     = 1'b1;
        o_hit_way = WIW'(w);
      end
      if (!i_valid[w]) begin
        o_free     = 1'b1;
        o_free_way = WIW'(w);
      end
    end
  end

endmodule

// File: rtl/gradient_accum_ctrl.sv
// Control stage in front of the set-associative gradient buffer. Takes
// (addr, grad) updates, reads the addressed set, accumulates on a hit,
// allocates or evicts on a miss, and streams out flushed gradients.
// Optional build macro GRAD_ACCUM_STATS_EN adds saturating event counters.
module gradient_accum_ctrl
  import grad_buf_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int NUM_WAYS    = 4,
  parameter int MAX_UPDATES = 255,
  parameter int THRESHOLD   = 1024,
  localparam int SIW        = calc_siw(DEPTH, NUM_WAYS),
  localparam int WIW        = calc_wiw(NUM_WAYS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_addr,
  input  logic [31:0]               in_grad,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_addr,
  output logic [31:0]               out_grad,
  output logic [1:0]                out_cause,
  output logic [SIW-1:0]            buf_rd_set_index,
  input  logic [NUM_WAYS-1:0]       buf_rd_valid,
  input  logic [NUM_WAYS-1:0][31:0] buf_rd_tag,
  input  logic [NUM_WAYS-1:0][31:0] buf_rd_accum,
  input  logic [NUM_WAYS-1:0][7:0]  buf_rd_upd_cnt,
  input  logic [WIW-1:0]            buf_rd_rr_ptr,
  output logic                      buf_wr_en,
  output logic [SIW-1:0]            buf_wr_set_index,
  output logic [WIW-1:0]            buf_wr_way,
  output logic                      buf_wr_valid,
  output logic [31:0]               buf_wr_tag,
  output logic [31:0]               buf_wr_accum,
  output logic [7:0]                buf_wr_upd_cnt,
  output logic                      buf_wr_rr_ptr_incr
`ifdef GRAD_ACCUM_STATS_EN
  ,
  output logic [31:0]               stat_hits,
  output logic [31:0]               stat_misses,
  output logic [31:0]               stat_evicts,
  output logic [31:0]               stat_flushes
`endif
);

  localparam int              NUM_SETS   = DEPTH / NUM_WAYS;
  localparam logic [SIW-1:0]  LAST_SET   = SIW'(NUM_SETS - 1);
  localparam logic [WIW-1:0]  LAST_WAY   = WIW'(NUM_WAYS - 1);
  localparam logic [32:0]     THRESH_MAG = 33'(THRESHOLD);
  localparam logic [7:0]      MAX_CNT    = 8'(MAX_UPDATES);

  ctrl_state_e    r_state, w_state_nxt;
  logic [31:0]    r_addr;
  logic [31:0]    r_grad;
  logic [SIW-1:0] r_set;
  logic [WIW-1:0] r_way;

  logic           w_hit, w_free;
  logic [WIW-1:0] w_hit_way, w_free_way;
  logic [31:0]    w_hit_sum;
  logic [8:0]     w_cnt_inc;
  logic [7:0]     w_hit_cnt;
  logic           w_hit_over, w_miss_over;
  logic           w_drain_step;

  grad_way_select #(
    .NUM_WAYS (NUM_WAYS),
    .WIW      (WIW)
  ) u_way_select (
    .i_valid    (buf_rd_valid),
    .i_tag      (buf_rd_tag),
    .i_addr     (r_addr),
    .o_hit      (w_hit),
    .o_hit_way  (w_hit_way),
    .o_free     (w_free),
    .o_free_way (w_free_way)
  );

  // Hit datapath: saturating accumulate, clamped count, threshold tests.
  always_comb begin
    w_hit_sum   = sat_add32(buf_rd_accum[w_hit_way], r_grad);
    w_cnt_inc   = {1'b0, buf_rd_upd_cnt[w_hit_way]} + 9'd1;
    w_hit_cnt   = (w_cnt_inc >= {1'b0, MAX_CNT}) ? MAX_CNT : w_cnt_inc[7:0];
    w_hit_over  = abs33(w_hit_sum) >= THRESH_MAG;
    w_miss_over = abs33(r_grad) >= THRESH_MAG;
  end

  // Next-state, output stream and buffer write sequencing.
  always_comb begin
    // NOTE: every signal gets a default up front so no path can infer a latch.
    w_state_nxt        = r_state;
    in_ready           = 1'b0;
    drain_done         = 1'b0;
    out_valid          = 1'b0;
    out_addr           = r_addr;
    out_grad           = r_grad;
    out_cause          = CAUSE_THRESH;
    buf_rd_set_index   = r_addr[SIW-1:0];
    buf_wr_en          = 1'b0;
    buf_wr_set_index   = r_addr[SIW-1:0];
    buf_wr_way         = '0;
    buf_wr_valid       = 1'b0;
    buf_wr_tag         = r_addr;
    buf_wr_accum       = r_grad;
    buf_wr_upd_cnt     = 8'd1;
    buf_wr_rr_ptr_incr = 1'b0;
    w_drain_step       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        in_ready = !rst && !drain_req;
        if (drain_req) begin
          w_state_nxt = ST_DRAIN;
        end else if (in_valid) begin
          w_state_nxt = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (w_hit) begin
          buf_wr_way     = w_hit_way;
          buf_wr_accum   = w_hit_sum;
          buf_wr_upd_cnt = w_hit_cnt;
          if (w_hit_over || (w_hit_cnt == MAX_CNT)) begin
            // Flush the accumulated value and retire the entry.
            out_valid = 1'b1;
            out_grad  = w_hit_sum;
            out_cause = w_hit_over ? CAUSE_THRESH : CAUSE_FORCE;
            if (out_ready) begin
              buf_wr_en   = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            buf_wr_valid = 1'b1;
            buf_wr_en    = 1'b1;
            w_state_nxt  = ST_IDLE;
          end
        end else if (w_miss_over) begin
          // Large enough on its own: pass straight through, buffer untouched.
          out_valid = 1'b1;
          if (out_ready) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_free) begin
          buf_wr_way   = w_free_way;
          buf_wr_valid = 1'b1;
          buf_wr_en    = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          // Set full: push out the round-robin victim and take its way.
          buf_wr_way   = buf_rd_rr_ptr;
          buf_wr_valid = 1'b1;
          out_valid    = 1'b1;
          out_addr     = buf_rd_tag[buf_rd_rr_ptr];
          out_grad     = buf_rd_accum[buf_rd_rr_ptr];
          out_cause    = CAUSE_EVICT;
          if (out_ready) begin
            buf_wr_en          = 1'b1;
            buf_wr_rr_ptr_incr = 1'b1;
            w_state_nxt        = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        buf_rd_set_index = r_set;
        buf_wr_set_index = r_set;
        buf_wr_way       = r_way;
        buf_wr_tag       = buf_rd_tag[r_way];
        buf_wr_accum     = buf_rd_accum[r_way];
        buf_wr_upd_cnt   = buf_rd_upd_cnt[r_way];
        if (buf_rd_valid[r_way]) begin
          out_valid = 1'b1;
          out_addr  = buf_rd_tag[r_way];
          out_grad  = buf_rd_accum[r_way];
          out_cause = CAUSE_DRAIN;
          if (out_ready) begin
            buf_wr_en    = 1'b1;
            w_drain_step = 1'b1;
          end
        end else begin
          w_drain_step = 1'b1;
        end
        if (w_drain_step && (r_set == LAST_SET) && (r_way == LAST_WAY)) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        drain_done  = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, captured request, and drain set/way walk.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_grad  <= '0;
      r_set   <= '0;
      r_way   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && in_valid && in_ready) begin
        r_addr <= in_addr;
        r_grad <= in_grad;
      end
      if ((r_state == ST_IDLE) && drain_req) begin
        r_set <= '0;
        r_way <= '0;
      end else if (w_drain_step) begin
        if (r_way == LAST_WAY) begin
          r_way <= '0;
          r_set <= r_set + SIW'(1);
        end else begin
          r_way <= r_way + WIW'(1);
        end
      end
    end
  end

`ifdef GRAD_ACCUM_STATS_EN
  logic        w_commit;
  logic [31:0] r_stat_hits, r_stat_misses, r_stat_evicts, r_stat_flushes;

  assign w_commit = (r_state == ST_LOOKUP) && (w_state_nxt == ST_IDLE);

  // Saturating event counters, bumped once when a lookup commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_hits    <= '0;
      r_stat_misses  <= '0;
      r_stat_evicts  <= '0;
      r_stat_flushes <= '0;
    end else if (w_commit) begin
      if (w_hit && (r_stat_hits != '1)) r_stat_hits <= r_stat_hits + 32'd1;
      if (!w_hit && (r_stat_misses != '1)) r_stat_misses <= r_stat_misses + 32'd1;
      if (buf_wr_rr_ptr_incr && (r_stat_evicts != '1)) r_stat_evicts <= r_stat_evicts + 32'd1;
      if (out_valid && (out_cause != CAUSE_EVICT) && (r_stat_flushes != '1)) begin
        r_stat_flushes <= r_stat_flushes + 32'd1;
      end
    end
  end

  assign stat_hits    = r_stat_hits;
  assign stat_misses  = r_stat_misses;
  assign stat_evicts  = r_stat_evicts;
  assign stat_flushes = r_stat_flushes;
`endif

endmodule

// File: tb/tb_gradient_accum_ctrl.sv
// Directed bench for gradient_accum_ctrl with a small behavioural model of
// the set-associative buffer storage (DEPTH=16, 4 ways, THRESHOLD=100).
module tb_gradient_accum_ctrl;
  import grad_buf_pkg::*;

  localparam int DEPTH       = 16;
  localparam int NUM_WAYS    = 4;
  localparam int NUM_SETS    = 4;
  localparam int MAX_UPDATES = 255;
  localparam int THRESHOLD   = 100;
  localparam int SIW         = 2;
  localparam int WIW         = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid, in_ready;
  logic [31:0]               in_addr, in_grad;
  logic                      drain_req, drain_done;
  logic                      out_valid, out_ready;
  logic [31:0]               out_addr, out_grad;
  logic [1:0]                out_cause;
  logic [SIW-1:0]            buf_rd_set_index;
  logic [NUM_WAYS-1:0]       buf_rd_valid;
  logic [NUM_WAYS-1:0][31:0] buf_rd_tag, buf_rd_accum;
  logic [NUM_WAYS-1:0][7:0]  buf_rd_upd_cnt;
  logic [WIW-1:0]            buf_rd_rr_ptr;
  logic                      buf_wr_en, buf_wr_valid, buf_wr_rr_ptr_incr;
  logic [SIW-1:0]            buf_wr_set_index;
  logic [WIW-1:0]            buf_wr_way;
  logic [31:0]               buf_wr_tag, buf_wr_accum;
  logic [7:0]                buf_wr_upd_cnt;

  always #5 clk = ~clk;

  gradient_accum_ctrl #(
    .DEPTH       (DEPTH),
    .NUM_WAYS    (NUM_WAYS),
    .MAX_UPDATES (MAX_UPDATES),
    .THRESHOLD   (THRESHOLD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_addr            (in_addr),
    .in_grad            (in_grad),
    .drain_req          (drain_req),
    .drain_done         (drain_done),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_addr           (out_addr),
    .out_grad           (out_grad),
    .out_cause          (out_cause),
    .buf_rd_set_index   (buf_rd_set_index),
    .buf_rd_valid       (buf_rd_valid),
    .buf_rd_tag         (buf_rd_tag),
    .buf_rd_accum       (buf_rd_accum),
    .buf_rd_upd_cnt     (buf_rd_upd_cnt),
    .buf_rd_rr_ptr      (buf_rd_rr_ptr),
    .buf_wr_en          (buf_wr_en),
    .buf_wr_set_index   (buf_wr_set_index),
    .buf_wr_way         (buf_wr_way),
    .buf_wr_valid       (buf_wr_valid),
    .buf_wr_tag         (buf_wr_tag),
    .buf_wr_accum       (buf_wr_accum),
    .buf_wr_upd_cnt     (buf_wr_upd_cnt),
    .buf_wr_rr_ptr_incr (buf_wr_rr_ptr_incr)
  );

  // Buffer storage model: combinational read, write on clock edge.
  logic           m_valid [NUM_SETS][NUM_WAYS];
  logic [31:0]    m_tag   [NUM_SETS][NUM_WAYS];
  logic [31:0]    m_accum [NUM_SETS][NUM_WAYS];
  logic [7:0]     m_cnt   [NUM_SETS][NUM_WAYS];
  logic [WIW-1:0] m_rr    [NUM_SETS];

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      buf_rd_valid[w]   = m_valid[buf_rd_set_index][w];
      buf_rd_tag[w]     = m_tag[buf_rd_set_index][w];
      buf_rd_accum[w]   = m_accum[buf_rd_set_index][w];
      buf_rd_upd_cnt[w] = m_cnt[buf_rd_set_index][w];
    end
    buf_rd_rr_ptr = m_rr[buf_rd_set_index];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        m_rr[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          m_valid[s][w] <= 1'b0;
          m_tag[s][w]   <= '0;
          m_accum[s][w] <= '0;
          m_cnt[s][w]   <= '0;
        end
      end
    end else if (buf_wr_en) begin
      m_valid[buf_wr_set_index][buf_wr_way] <= buf_wr_valid;
      m_tag[buf_wr_set_index][buf_wr_way]   <= buf_wr_tag;
      m_accum[buf_wr_set_index][buf_wr_way] <= buf_wr_accum;
      m_cnt[buf_wr_set_index][buf_wr_way]   <= buf_wr_upd_cnt;
      if (buf_wr_rr_ptr_incr) m_rr[buf_wr_set_index] <= m_rr[buf_wr_set_index] + 2'd1;
    end
  end

  // Output-stream log and event counters, sampled mid-cycle.
  logic [31:0] log_addr [$];
  logic [31:0] log_grad [$];
  logic [1:0]  log_cause[$];
  int          wr_cnt   = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      log_addr.push_back(out_addr);
      log_grad.push_back(out_grad);
      log_cause.push_back(out_cause);
    end
    if (!rst && buf_wr_en) wr_cnt <= wr_cnt + 1;
    if (drain_done) done_cnt <= done_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int idx, input logic [31:0] a,
                           input logic [31:0] g, input logic [1:0] c);
    if (log_addr.size() <= idx) begin
      check({tag, "_present"}, 32'(log_addr.size()), 32'(idx + 1));
    end else begin
      check({tag, "_addr"}, log_addr[idx], a);
      check({tag, "_grad"}, log_grad[idx], g);
      check({tag, "_cause"}, 32'(log_cause[idx]), 32'(c));
    end
  endtask

  // Returns at a falling edge where in_ready is high, or flags a timeout.
  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Issue one update and wait for the controller to come back to idle.
  task automatic send(input logic [31:0] a, input logic [31:0] g);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = a;
    in_grad  = g;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_ready();
  endtask

  // Issue one update that will stall on the output; returns in LOOKUP.
  task automatic send_no_wait(input logic [31:0] a, input logic [31:0] g);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_addr  = a;
    in_grad  = g;
    wait_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  int base_wr;
  int base_log;
  int base_done;
  int n_valid;
  int stall_bad;
  bit seen_done;

  initial begin
    in_valid  = 1'b0;
    in_addr   = '0;
    in_grad   = '0;
    drain_req = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_drain_done", 32'(drain_done), 32'd0);
    check("rst_wr_en", 32'(buf_wr_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Accumulate 30+30+30 silently, then +50 crosses the threshold at 140
    send(32'h10, 32'd30);
    send(32'h10, 32'd30);
    send(32'h10, 32'd30);
    check("acc_no_out", 32'(log_addr.size()), 32'd0);
    check("acc_accum", m_accum[0][0], 32'd90);
    check("acc_cnt", 32'(m_cnt[0][0]), 32'd3);
    send(32'h10, 32'd50);
    check_out("thresh", 0, 32'h10, 32'd140, CAUSE_THRESH);
    check("thresh_invalid", 32'(m_valid[0][0]), 32'd0);

    // Fill set 0, then the fifth address evicts way 0 (rr_ptr 0)
    send(32'h0, 32'd1);
    send(32'h4, 32'd2);
    send(32'h8, 32'd3);
    send(32'hC, 32'd4);
    check("fill_no_out", 32'(log_addr.size()), 32'd1);
    send(32'h10, 32'd5);
    check_out("evict", 1, 32'h0, 32'd1, CAUSE_EVICT);
    check("evict_tag", m_tag[0][0], 32'h10);
    check("evict_accum", m_accum[0][0], 32'd5);
    check("evict_rr", 32'(m_rr[0]), 32'd1);

    // Miss with |grad| >= threshold bypasses the full set without a write
    base_wr = wr_cnt;
    send(32'h20, -32'sd150);
    check_out("bypass", 2, 32'h20, 32'hFFFF_FF6A, CAUSE_THRESH);
    check("bypass_no_wr", 32'(wr_cnt), 32'(base_wr));
    check("bypass_tag0", m_tag[0][0], 32'h10);
    check("bypass_rr", 32'(m_rr[0]), 32'd1);

    // Saturating accumulate, both directions (set 2)
    send(32'hA, 32'd50);
    send(32'hA, 32'h7FFF_FFF0);
    check_out("sat_pos", 3, 32'hA, 32'h7FFF_FFFF, CAUSE_THRESH);
    send(32'h6, -32'sd50);
    send(32'h6, 32'h8000_0000);
    check_out("sat_neg", 4, 32'h6, 32'h8000_0000, CAUSE_THRESH);

    // Threshold boundary: 99 stays, 100 flushes (set 3)
    send(32'h7, 32'd60);
    send(32'h7, 32'd39);
    check("bnd_99_no_out", 32'(log_addr.size()), 32'd5);
    check("bnd_99_accum", m_accum[3][0], 32'd99);
    send(32'h7, 32'd1);
    check_out("bnd_100", 5, 32'h7, 32'd100, CAUSE_THRESH);

    // Force flush once the update count reaches MAX_UPDATES (set 1)
    send(32'h5, 32'd3);
    for (int i = 0; i < MAX_UPDATES - 2; i++) send(32'h5, 32'd0);
    check("force_no_out", 32'(log_addr.size()), 32'd6);
    check("force_cnt", 32'(m_cnt[1][0]), 32'(MAX_UPDATES - 1));
    send(32'h5, 32'd0);
    check_out("force", 6, 32'h5, 32'd3, CAUSE_FORCE);
    check("force_invalid", 32'(m_valid[1][0]), 32'd0);

    // Eviction held by downstream back-pressure for 5 cycles (victim way 1)
    out_ready = 1'b0;
    base_wr   = wr_cnt;
    send_no_wait(32'h14, 32'd7);
    stall_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || out_addr !== 32'h4 || out_grad !== 32'd2 ||
          out_cause !== 2'(CAUSE_EVICT) || in_ready || buf_wr_en) stall_bad++;
    end
    check("stall_stable", 32'(stall_bad), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_wr_en", 32'(buf_wr_en), 32'd1);
    check("stall_rr_incr", 32'(buf_wr_rr_ptr_incr), 32'd1);
    check("stall_wr_way", 32'(buf_wr_way), 32'd1);
    wait_ready();
    check_out("stall_evict", 7, 32'h4, 32'd2, CAUSE_EVICT);
    check("stall_wr_once", 32'(wr_cnt - base_wr), 32'd1);
    check("stall_tag", m_tag[0][1], 32'h14);
    check("stall_rr", 32'(m_rr[0]), 32'd2);

    // Reset while an eviction is pending drops it
    out_ready = 1'b0;
    send_no_wait(32'h18, 32'd1);
    @(negedge clk);
    check("abort_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_wr_en", 32'(buf_wr_en), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'(in_ready), 32'd1);
    check("abort_no_out", 32'(log_addr.size()), 32'd8);

    // Drain three entries (sets 0, 0, 2); a same-cycle update is refused
    send(32'h0, 32'd11);
    send(32'h4, 32'd12);
    send(32'h2, 32'd13);
    base_log  = log_addr.size();
    base_done = done_cnt;
    @(posedge clk); #1;
    drain_req = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 32'h8;
    in_grad   = 32'd9;
    @(negedge clk);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    drain_req = 1'b0;
    in_valid  = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      @(negedge clk);
      if (drain_done) seen_done = 1'b1;
    end
    check("drain_done_seen", 32'(seen_done), 32'd1);
    repeat (4) @(negedge clk);
    check("drain_done_once", 32'(done_cnt - base_done), 32'd1);
    check("drain_count", 32'(log_addr.size() - base_log), 32'd3);
    check_out("drain0", base_log, 32'h0, 32'd11, CAUSE_DRAIN);
    check_out("drain1", base_log + 1, 32'h4, 32'd12, CAUSE_DRAIN);
    check_out("drain2", base_log + 2, 32'h2, 32'd13, CAUSE_DRAIN);
    n_valid = 0;
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++)
        if (m_valid[s][w]) n_valid++;
    check("drain_all_invalid", 32'(n_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gradient_accum_ctrl.md
Name: gradient_accum_ctrl

Overview:
- Control stage directly upstream of the set-associative gradient buffer. Accepts gradient updates (addr, grad) over a valid/ready stream.
- Reads the addressed set, then either accumulates on a hit, allocates on a miss, or evicts the round-robin victim.
- Emits flushed gradients on an output stream for threshold, force-flush, eviction and drain events.
- Owns all buffer read/write sequencing; the buffer holds storage only.

Parameters:
- DEPTH, 256, total buffer entries (must match buffer)
- NUM_WAYS, 4, associativity (must match buffer)
- MAX_UPDATES, 255, upd_cnt value that triggers force-flush (≤255)
- THRESHOLD, 1024, unsigned magnitude at/above which an accumulated value flushes

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- in_valid  in  1  update valid
- in_ready  out  1  update accepted when in_valid&in_ready
- in_addr  in  32  gradient address (tag = full addr; set = in_addr[SIW-1:0], SIW=$clog2(DEPTH/NUM_WAYS))
- in_grad  in  32  signed gradient
- drain_req  in  1  pulse: flush every valid entry
- drain_done  out  1  one-cycle pulse when drain completes
- out_valid  out  1  flushed gradient valid
- out_ready  in  1  downstream ready
- out_addr  out  32  flushed address
- out_grad  out  32  flushed signed value
- out_cause  out  2  0 THRESH, 1 FORCE, 2 EVICT, 3 DRAIN
- buf_rd_set_index  out  SIW  buffer read set
- buf_rd_valid/tag/accum/upd_cnt/rr_ptr  in  per-way arrays  buffer read data (combinational)
- buf_wr_en, buf_wr_set_index, buf_wr_way, buf_wr_valid, buf_wr_tag, buf_wr_accum, buf_wr_upd_cnt, buf_wr_rr_ptr_incr  out  matching buffer widths  buffer write

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-high (rst).
- Buffer's rst_n is driven with ~rst at the top level.
- Reset values:
  - State IDLE.
  - in_ready=0 during reset.
  - out_valid=0, drain_done=0, buf_wr_en=0.
  - Registered addr/grad, set/way counters: 0.
- Reset mid-operation aborts any pending output or drain; nothing is replayed.
- FSM states: IDLE, LOOKUP, DRAIN, DONE.
- IDLE:
  - in_ready = ~drain_req.
  - drain_req wins over in_valid: go to DRAIN with set=way=0.
  - On in handshake: register addr/grad, go to LOOKUP.
- LOOKUP:
  - buf_rd_set_index = registered set.
  - Hit = any way valid with tag==addr. At most one way hits (invariant).
  - Hit: new = sat32(accum+grad), signed saturating to ±(2^31-1 / -2^31). cnt = min(upd_cnt+1, MAX_UPDATES).
    - If |new| ≥ THRESHOLD (33-bit magnitude): emit cause THRESH, write valid=0.
    - Else if cnt==MAX_UPDATES: emit cause FORCE, write valid=0.
    - Else: write valid=1 with new and cnt, no output.
  - Miss with |grad| ≥ THRESHOLD: bypass. Emit grad with cause THRESH; no buffer write.
  - Miss with free way: write the lowest-index invalid way (valid=1, tag=addr, accum=grad, upd_cnt=1).
  - Miss, set full: victim = rr_ptr. Emit victim tag/accum with cause EVICT. Write the new entry into the victim way with buf_wr_rr_ptr_incr=1.
  - rr_ptr_incr is asserted only on eviction.
  - Outputs are combinational from the registered request and buffer read data. They stay stable while out_valid && !out_ready.
  - buf_wr_en is asserted only in the cycle the output handshakes, or immediately if no output is needed.
  - Then return to IDLE. Throughput is 1 update per 2 cycles minimum; RAW is hazard-free because the write completes before the next lookup.
- DRAIN:
  - Read set s.
  - If way w is valid: emit tag/accum with cause DRAIN; on handshake write valid=0.
  - If invalid: skip in one cycle.
  - Advance w, then s. After set NUM_SETS-1 way NUM_WAYS-1, go to DONE.
  - in_ready=0 throughout. Further drain_req is ignored.
- DONE: drain_done=1 for one cycle, then IDLE.

Optional Feature:
- GRAD_ACCUM_STATS_EN defined: adds outputs stat_hits, stat_misses, stat_evicts, stat_flushes (32-bit, saturating, reset 0).
  - Each increments once per committed event; flushes count THRESH+FORCE+bypass.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package grad_buf_pkg: flush_cause_e enum (THRESH/FORCE/EVICT/DRAIN), state enum, and SIW/WIW derivation functions.
- sat_add32 function for the saturating add.
- One sub-module: grad_way_select. Combinational; given per-way valid/tag and addr, returns hit, hit_way, free, free_way.

Test Plan (DEPTH=16, NUM_WAYS=4, THRESHOLD=100, out_ready=1 unless stated):
- addr 0x10 grad 30 ×3 then 50 → no output for first three; fourth gives out addr 0x10 grad 140 cause THRESH; entry invalid afterwards.
- grads 1..5 to addrs 0x0,0x4,0x8,0xC,0x10 (all set 0) → fifth gives out addr 0x0 grad 1 cause EVICT; way0 holds 0x10/5; rr_ptr=1.
- new addr 0x20 grad -150 → out grad -150 cause THRESH; no buf_wr_en; set contents unchanged.
- MAX_UPDATES=3, addr 0x4 grad 1 ×3 → third gives out grad 3 cause FORCE.
- Eviction with out_ready low 5 cycles → out_* stable, in_ready=0, no buf_wr_en until handshake; then write and rr_ptr increment in that cycle.
- 3 valid entries in sets 0,0,2, then drain_req → 3 DRAIN outputs in set/way order, then drain_done pulse; all entries invalid; drain_req with in_valid same cycle → update not accepted.
